// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipe_pkg                                                  |
// | Purpose  : Shared constants, stage bundle type and forwarding helper |
// |            for the pipeline control / hazard unit.                   |
// | Revision : 1.0 - initial parametrised release                        |
// +----------------------------------------------------------------------+
package pipe_pkg;

   // Forwarding mux selects for the E-stage ALU operands
   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_M  = 2'b10;
   localparam logic [1:0] FWD_W  = 2'b01;

   // Default widths of the canonical stage bundle
   localparam int DEF_CTRL_W = 8;
   localparam int DEF_RA_W   = 5;

   // Fields carried by every pipeline stage register, MSB first
   typedef struct packed {
      logic [DEF_CTRL_W-1:0] ctrl;
      logic                  regwrite;
      logic                  memtoreg;
      logic                  memwrite;
      logic [DEF_RA_W-1:0]   dst;
   } stage_t;

   // M result is younger than W, so an M hit wins over a W hit
   function automatic logic [1:0] fwdSelect(input logic hitM, input logic hitW);
      logic [1:0] sel;
      sel = FWD_RF;
      if (hitM)
         sel = FWD_M;
      else if (hitW)
         sel = FWD_W;
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipe_stage_reg                                            |
// | Purpose  : Pipeline register with hold (En low) and bubble (Clr).    |
// | Revision : 1.0 - initial parametrised release                        |
// +----------------------------------------------------------------------+
module pipe_stage_reg #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             En,
   input  logic             Clr,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   logic [WIDTH-1:0] r_q;

   // Bubble has priority over load; En low holds the current contents
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)
         r_q <= '0;
      else if (Clr)
         r_q <= '0;
      else if (En)
         r_q <= D;
   end

   assign Q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_hazard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipe_ctrl_hazard                                          |
// | Purpose  : Stages the decoder control word D->E->M->W and resolves   |
// |            forwarding, load-use/branch stalls, flushes and memory    |
// |            wait freezes; counts stall cycles.                        |
// | Revision : 1.0 - initial parametrised release                        |
// +----------------------------------------------------------------------+
module pipe_ctrl_hazard
   import pipe_pkg::*;
#(
   parameter int CTRL_W       = 8,
   parameter int RA_W         = 5,
   parameter int CNT_W        = 16,
   parameter int USE_MEM_WAIT = 1
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [CTRL_W-1:0] CtrlD,
   input  logic              RegWriteD,
   input  logic              MemToRegD,
   input  logic              MemWriteD,
   input  logic              BranchD,
   input  logic              PCSrcD,
   input  logic [RA_W-1:0]   RsD,
   input  logic [RA_W-1:0]   RtD,
   input  logic [RA_W-1:0]   RsE,
   input  logic [RA_W-1:0]   RtE,
   input  logic [RA_W-1:0]   DstRegD,
   input  logic              MemReadyM,
   input  logic              CntClr,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              ForwardAD,
   output logic              ForwardBD,
   output logic [CTRL_W-1:0] CtrlE,
   output logic [CTRL_W-1:0] CtrlM,
   output logic [CTRL_W-1:0] CtrlW,
   output logic              RegWriteE,
   output logic              RegWriteM,
   output logic              RegWriteW,
   output logic              MemToRegE,
   output logic              MemToRegM,
   output logic              MemToRegW,
   output logic              MemWriteM,
   output logic [RA_W-1:0]   DstRegE,
   output logic [RA_W-1:0]   DstRegM,
   output logic [RA_W-1:0]   DstRegW,
   output logic [CNT_W-1:0]  StallCnt
);

   // Same field order as pipe_pkg::stage_t, sized by this instance
   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic              regwrite;
      logic              memtoreg;
      logic              memwrite;
      logic [RA_W-1:0]   dst;
   } stageBundle_t;

   localparam int c_STAGE_W = $bits(stageBundle_t);

   stageBundle_t     w_stageD;
   stageBundle_t     r_stageE;
   stageBundle_t     r_stageM;
   stageBundle_t     r_stageW;
   logic             w_memWait;
   logic             w_lwStall;
   logic             w_brStall;
   logic             w_hazStall;
   logic             w_stall;
   logic             w_enE;
   logic             w_clrE;
   logic             w_enM;
   logic             w_clrW;
   logic             w_flushD;
   logic             w_flushE;
   logic             w_wrM;
   logic             w_wrW;
   logic             w_wrE;
   logic             w_ldM;
   logic [CNT_W-1:0] r_stallCnt;

   assign w_stageD = '{ctrl: CtrlD, regwrite: RegWriteD, memtoreg: MemToRegD,
                       memwrite: MemWriteD, dst: DstRegD};

   generate
      if (USE_MEM_WAIT != 0) begin : g_memWait
         assign w_memWait = (r_stageM.memtoreg | r_stageM.memwrite) & ~MemReadyM;
      end else begin : g_noMemWait
         logic w_unusedMemReady;
         assign w_unusedMemReady = MemReadyM;
         assign w_memWait        = 1'b0;
      end
   endgenerate

   // Register-0 writes never take part in forwarding or hazard checks
   assign w_wrE = r_stageE.regwrite & (r_stageE.dst != '0);
   assign w_wrM = r_stageM.regwrite & (r_stageM.dst != '0);
   assign w_wrW = r_stageW.regwrite & (r_stageW.dst != '0);
   assign w_ldM = r_stageM.memtoreg & (r_stageM.dst != '0);

   // Hazard detection and stall/flush priority: memory wait, then data hazards, then redirect
   always_comb begin
      w_lwStall  = r_stageE.memtoreg & (r_stageE.dst != '0) &
                   ((r_stageE.dst == RsD) | (r_stageE.dst == RtD));
      w_brStall  = BranchD &
                   ((w_wrE & ((r_stageE.dst == RsD) | (r_stageE.dst == RtD))) |
                    (w_ldM & ((r_stageM.dst == RsD) | (r_stageM.dst == RtD))));
      w_hazStall = w_lwStall | w_brStall;
      w_stall    = w_memWait | w_hazStall;
      w_flushE   = ~w_memWait & w_hazStall;
      w_flushD   = ~w_memWait & ~w_hazStall & PCSrcD;
      // A freeze holds E and M and drains W; a data hazard bubbles E only
      w_enE      = ~w_memWait;
      w_clrE     = w_flushE;
      w_enM      = ~w_memWait;
      w_clrW     = w_memWait;
   end

   // Forwarding selects toward the E-stage ALU and the D-stage comparator
   always_comb begin
      ForwardAE = fwdSelect(w_wrM & (r_stageM.dst == RsE), w_wrW & (r_stageW.dst == RsE));
      ForwardBE = fwdSelect(w_wrM & (r_stageM.dst == RtE), w_wrW & (r_stageW.dst == RtE));
      ForwardAD = w_wrM & (r_stageM.dst == RsD);
      ForwardBD = w_wrM & (r_stageM.dst == RtD);
   end

   pipe_stage_reg #(.WIDTH(c_STAGE_W)) uStageE (
      .CLK(CLK), .Reset(Reset), .En(w_enE), .Clr(w_clrE), .D(w_stageD), .Q(r_stageE));

   pipe_stage_reg #(.WIDTH(c_STAGE_W)) uStageM (
      .CLK(CLK), .Reset(Reset), .En(w_enM), .Clr(1'b0), .D(r_stageE), .Q(r_stageM));

   pipe_stage_reg #(.WIDTH(c_STAGE_W)) uStageW (
      .CLK(CLK), .Reset(Reset), .En(1'b1), .Clr(w_clrW), .D(r_stageM), .Q(r_stageW));

   // Saturating stall-cycle counter; clear wins over increment
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)
         r_stallCnt <= '0;
      else if (CntClr)
         r_stallCnt <= '0;
      else if (w_stall && (r_stallCnt != '1))
         r_stallCnt <= r_stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign StallF    = w_stall;
   assign StallD    = w_stall;
   assign FlushD    = w_flushD;
   assign FlushE    = w_flushE;
   assign CtrlE     = r_stageE.ctrl;
   assign CtrlM     = r_stageM.ctrl;
   assign CtrlW     = r_stageW.ctrl;
   assign RegWriteE = r_stageE.regwrite;
   assign RegWriteM = r_stageM.regwrite;
   assign RegWriteW = r_stageW.regwrite;
   assign MemToRegE = r_stageE.memtoreg;
   assign MemToRegM = r_stageM.memtoreg;
   assign MemToRegW = r_stageW.memtoreg;
   assign MemWriteM = r_stageM.memwrite;
   assign DstRegE   = r_stageE.dst;
   assign DstRegM   = r_stageM.dst;
   assign DstRegW   = r_stageW.dst;
   assign StallCnt  = r_stallCnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_hazard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pipe_ctrl_hazard                                       |
// | Purpose  : Directed self-checking bench for pipe_ctrl_hazard.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_pipe_ctrl_hazard;

   logic       CLK = 1'b0;
   logic       Reset;
   logic [7:0] CtrlD;
   logic       RegWriteD, MemToRegD, MemWriteD, BranchD, PCSrcD;
   logic [4:0] RsD, RtD, RsE, RtE, DstRegD;
   logic       MemReadyM, CntClr;
   logic       StallF, StallD, FlushD, FlushE;
   logic [1:0] ForwardAE, ForwardBE;
   logic       ForwardAD, ForwardBD;
   logic [7:0] CtrlE, CtrlM, CtrlW;
   logic       RegWriteE, RegWriteM, RegWriteW;
   logic       MemToRegE, MemToRegM, MemToRegW, MemWriteM;
   logic [4:0] DstRegE, DstRegM, DstRegW;
   logic [3:0] StallCnt;

   int nVec = 0;
   int nErr = 0;

   pipe_ctrl_hazard #(.CTRL_W(8), .RA_W(5), .CNT_W(4), .USE_MEM_WAIT(1)) dut (
      .CLK(CLK), .Reset(Reset), .CtrlD(CtrlD), .RegWriteD(RegWriteD),
      .MemToRegD(MemToRegD), .MemWriteD(MemWriteD), .BranchD(BranchD),
      .PCSrcD(PCSrcD), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .DstRegD(DstRegD), .MemReadyM(MemReadyM), .CntClr(CntClr),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD),
      .ForwardBD(ForwardBD), .CtrlE(CtrlE), .CtrlM(CtrlM), .CtrlW(CtrlW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemToRegE(MemToRegE), .MemToRegM(MemToRegM), .MemToRegW(MemToRegW),
      .MemWriteM(MemWriteM), .DstRegE(DstRegE), .DstRegM(DstRegM),
      .DstRegW(DstRegW), .StallCnt(StallCnt));

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic setD(input logic [7:0] c, input logic rw, input logic mtr, input logic mw,
                       input logic br, input logic pc, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] dst);
      CtrlD = c; RegWriteD = rw; MemToRegD = mtr; MemWriteD = mw;
      BranchD = br; PCSrcD = pc; RsD = rs; RtD = rt; DstRegD = dst;
   endtask

   task automatic setE(input logic [4:0] rs, input logic [4:0] rt);
      RsE = rs; RtE = rt;
   endtask

   // Advance one clock, resume just after the edge
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // D register must never be stalled and flushed together
   always @(negedge CLK) begin
      if (Reset) begin
         nVec++;
         assert (!(StallD && FlushD)) else begin
            nErr++;
            $error("FAIL stallD_flushD: observed 1 expected 0");
         end
      end
   end

   initial begin
      Reset = 1'b0; MemReadyM = 1'b1; CntClr = 1'b0;
      setD(8'h00, 0, 0, 0, 0, 0, 0, 0, 0); setE(0, 0);
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_StallF", StallF, 0);   chk("rst_FlushD", FlushD, 0);
      chk("rst_FlushE", FlushE, 0);   chk("rst_FwdAE", ForwardAE, 0);
      chk("rst_CtrlE", CtrlE, 0);     chk("rst_RegWriteW", RegWriteW, 0);
      chk("rst_StallCnt", StallCnt, 0);
      Reset = 1'b1;

      // add r3 <- r1,r2
      setD(8'hA1, 1, 0, 0, 0, 0, 1, 2, 3); setE(0, 0); #2;
      chk("t1a_StallF", StallF, 0);
      step();
      // sub r4 <- r3,r5 (add now in E)
      setD(8'hB2, 1, 0, 0, 0, 0, 3, 5, 4); setE(1, 2); #2;
      chk("t1b_CtrlE", CtrlE, 8'hA1); chk("t1b_DstRegE", DstRegE, 3);
      chk("t1b_FwdAE", ForwardAE, 2'b00);
      step();
      // or r6 <- r3,r0 in D; sub in E, add in M
      setD(8'hC3, 1, 0, 0, 0, 0, 3, 0, 6); setE(3, 5); #2;
      chk("t1c_FwdAE", ForwardAE, 2'b10); chk("t1c_FwdBE", ForwardBE, 2'b00);
      chk("t1c_FwdAD", ForwardAD, 1);     chk("t1c_DstRegM", DstRegM, 3);
      step();
      // or in E, sub in M, add in W
      setD(8'h00, 0, 0, 0, 0, 0, 0, 0, 0); setE(3, 0); #2;
      chk("t1d_FwdAE", ForwardAE, 2'b01); chk("t1d_CtrlW", CtrlW, 8'hA1);
      chk("t1d_DstRegW", DstRegW, 3);
      step();

      // lw r2
      setD(8'h44, 1, 1, 0, 0, 0, 1, 0, 2); setE(0, 0); #2;
      chk("t2a_StallF", StallF, 0);
      step();
      // add r7 <- r0,r2 behind the load
      setD(8'h55, 1, 0, 0, 0, 0, 0, 2, 7); setE(1, 0); #2;
      chk("t2b_StallF", StallF, 1); chk("t2b_StallD", StallD, 1);
      chk("t2b_FlushE", FlushE, 1); chk("t2b_FlushD", FlushD, 0);
      chk("t2b_StallCnt", StallCnt, 0);
      step();
      setE(0, 0); #2;
      chk("t2c_StallF", StallF, 0); chk("t2c_FlushE", FlushE, 0);
      chk("t2c_CtrlE_bubble", CtrlE, 0); chk("t2c_StallCnt", StallCnt, 1);
      step();
      setD(8'h00, 0, 0, 0, 0, 0, 0, 0, 0); setE(0, 2); #2;
      chk("t2d_FwdAE", ForwardAE, 2'b00); chk("t2d_FwdBE", ForwardBE, 2'b01);
      chk("t2d_MemToRegW", MemToRegW, 1);
      step();

      // addi r4 then beq r4,r0
      setD(8'h66, 1, 0, 0, 0, 0, 1, 0, 4); setE(0, 0); #2;
      step();
      setD(8'h77, 0, 0, 0, 1, 0, 4, 0, 0); setE(1, 0); #2;
      chk("t3a_StallF", StallF, 1); chk("t3a_FlushE", FlushE, 1);
      chk("t3a_FlushD", FlushD, 0); chk("t3a_FwdAD", ForwardAD, 0);
      step();
      setD(8'h77, 0, 0, 0, 1, 1, 4, 0, 0); setE(0, 0); #2;
      chk("t3b_StallF", StallF, 0); chk("t3b_FwdAD", ForwardAD, 1);
      chk("t3b_FlushD", FlushD, 1); chk("t3b_StallCnt", StallCnt, 2);
      step();

      // lw r5, then or r8 <- r6,r7
      setD(8'h88, 1, 1, 0, 0, 0, 1, 0, 5); setE(4, 0); #2;
      step();
      setD(8'hAB, 1, 0, 0, 0, 0, 6, 7, 8); setE(1, 0); #2;
      chk("t4a_StallF", StallF, 0);
      step();
      // load stuck in M while a taken redirect sits in D
      MemReadyM = 1'b0;
      setD(8'h99, 0, 0, 1, 0, 1, 6, 7, 0); setE(6, 7); #2;
      chk("t4b_StallF", StallF, 1); chk("t4b_FlushD", FlushD, 0);
      chk("t4b_FlushE", FlushE, 0); chk("t4b_CtrlM", CtrlM, 8'h88);
      for (int i = 0; i < 2; i++) begin
         step(); #1;
         chk("t4c_CtrlE_hold", CtrlE, 8'hAB); chk("t4c_DstRegE_hold", DstRegE, 8);
         chk("t4c_CtrlM_hold", CtrlM, 8'h88); chk("t4c_DstRegM_hold", DstRegM, 5);
         chk("t4c_RegWriteW", RegWriteW, 0); chk("t4c_FlushD", FlushD, 0);
         chk("t4c_StallF", StallF, 1);
      end
      step();
      MemReadyM = 1'b1; #2;
      chk("t4d_StallCnt", StallCnt, 5); chk("t4d_StallF", StallF, 0);
      chk("t4d_FlushD", FlushD, 1);
      step();
      setD(8'h00, 0, 0, 0, 0, 0, 0, 0, 0); setE(0, 0); #2;
      chk("t4e_RegWriteW", RegWriteW, 1); chk("t4e_DstRegW", DstRegW, 5);
      chk("t4e_MemWriteM", MemWriteM, 0);
      step(); #1;
      chk("t4f_MemWriteM", MemWriteM, 1);

      // writes to r0 everywhere
      setD(8'hCC, 1, 1, 0, 0, 0, 0, 0, 0); #2;
      step(); #1;
      chk("t5a_StallF", StallF, 0);
      step();
      setD(8'hCC, 1, 1, 0, 1, 0, 0, 0, 0); #2;
      chk("t5b_StallF", StallF, 0);
      step();
      setD(8'h00, 0, 0, 0, 1, 0, 0, 0, 0); #2;
      chk("t5c_RegWriteW", RegWriteW, 1);
      chk("t5c_FwdAE", ForwardAE, 2'b00); chk("t5c_FwdBE", ForwardBE, 2'b00);
      chk("t5c_FwdAD", ForwardAD, 0);     chk("t5c_FwdBD", ForwardBD, 0);
      chk("t5c_StallF", StallF, 0);       chk("t5c_StallCnt", StallCnt, 5);

      // counter saturation, clear during a stall, reset during a freeze
      setD(8'h00, 0, 0, 0, 0, 0, 0, 0, 0); MemReadyM = 1'b0; #2;
      chk("t6a_StallF", StallF, 1);
      repeat (10) step();
      #1; chk("t6b_StallCnt_sat", StallCnt, 4'hF);
      step(); #1;
      chk("t6c_StallCnt_hold", StallCnt, 4'hF);
      CntClr = 1'b1;
      step(); #1;
      chk("t6d_StallCnt_clr", StallCnt, 0);
      CntClr = 1'b0;
      step(); #1;
      chk("t6e_StallCnt_one", StallCnt, 1);
      Reset = 1'b0; #1;
      chk("t6f_StallF", StallF, 0);       chk("t6f_MemToRegM", MemToRegM, 0);
      chk("t6f_RegWriteM", RegWriteM, 0); chk("t6f_CtrlE", CtrlE, 0);
      chk("t6f_StallCnt", StallCnt, 0);
      repeat (2) step();
      Reset = 1'b1;
      step(); #1;
      chk("t6g_StallF", StallF, 0); chk("t6g_StallCnt", StallCnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
`default_nettype wire
